// File: rtl/montgomery_req_scheduler.sv
// montgomery_req_scheduler: round-robin sharing of one pipelined Montgomery reducer, draining it before any modulus change
module montgomery_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LENGTH = 64,
  parameter int LATENCY     = 21,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_q_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_qbl_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_qinv_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [ID_W-1:0]                resp_id_o,
  output logic [DATA_LENGTH-1:0]         resp_data_o,
  output logic                           mr_start_o,
  output logic [DATA_LENGTH-1:0]         mr_x_o,
  output logic [DATA_LENGTH-1:0]         mr_q_o,
  output logic [DATA_LENGTH-1:0]         mr_q_bl_o,
  output logic [DATA_LENGTH-1:0]         mr_qinv_o,
  input  logic [DATA_LENGTH-1:0]         mr_result_i,
  input  logic                           mr_valid_i,
  output logic                           busy_o,
  output logic                           err_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {S_RUN, S_DRAIN} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, lock_id, cand, mr_id;
  logic [ID_W:0] sum;
  logic cand_ok, cfg_valid, cfg_match, idle, can_issue, issue, push, pop, full, tail_ok;
  logic [DATA_LENGTH-1:0] cand_x, cand_q, cand_qbl, cand_qinv;
  logic [CW-1:0] inflight, fifo_count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0] tag_id [LATENCY];
  logic [DATA_LENGTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ID_W-1:0] fifo_id [FIFO_DEPTH];
  // Searching downward lets the requester nearest rr_ptr win the last assignment.
  always_comb begin
    cand_ok = 1'b0;
    cand = rr_ptr;
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      sum = sum >= (ID_W+1)'(NUM_REQ) ? sum - (ID_W+1)'(NUM_REQ) : sum;
      if (req_valid_i[sum[ID_W-1:0]]) begin
        cand_ok = 1'b1;
        cand = sum[ID_W-1:0];
      end
    end
    cand_ok = state == S_DRAIN ? req_valid_i[lock_id] : cand_ok;
    cand = state == S_DRAIN ? lock_id : cand;
    cand_x = '0;
    cand_q = '0;
    cand_qbl = '0;
    cand_qinv = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (cand == ID_W'(i)) begin
        cand_x = req_x_i[i*DATA_LENGTH +: DATA_LENGTH];
        cand_q = req_q_i[i*DATA_LENGTH +: DATA_LENGTH];
        cand_qbl = req_qbl_i[i*DATA_LENGTH +: DATA_LENGTH];
        cand_qinv = req_qinv_i[i*DATA_LENGTH +: DATA_LENGTH];
      end
  end
  assign idle = inflight == '0;
  assign can_issue = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign cfg_match = cfg_valid && cand_q == mr_q_o && cand_qbl == mr_q_bl_o && cand_qinv == mr_qinv_o;
  assign issue = rst_ni && cand_ok && can_issue && (state == S_RUN ? cfg_match || idle : idle);
  assign req_ready_o = issue ? NUM_REQ'(1) << cand : '0;
  assign tail_ok = tag_v[LATENCY-1];
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign resp_valid_o = fifo_count != '0;
  assign pop = resp_valid_o && resp_ready_i;
  assign push = mr_valid_i && (!full || pop);
  assign resp_id_o = resp_valid_o ? fifo_id[rd_ptr] : '0;
  assign resp_data_o = resp_valid_o ? fifo_data[rd_ptr] : '0;
  assign busy_o = !idle || resp_valid_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_RUN;
      rr_ptr <= '0;
      lock_id <= '0;
      mr_id <= '0;
      cfg_valid <= 1'b0;
      mr_start_o <= 1'b0;
      mr_x_o <= '0;
      mr_q_o <= '0;
      mr_q_bl_o <= '0;
      mr_qinv_o <= '0;
      inflight <= '0;
      fifo_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag_v <= '0;
      err_o <= 1'b0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
    end else begin
      mr_start_o <= issue;
      if (issue) begin
        mr_x_o <= cand_x;
        mr_id <= cand;
        rr_ptr <= cand == ID_W'(NUM_REQ - 1) ? '0 : cand + ID_W'(1);
      end
      // Config only changes with the reducer empty, so in-flight operands keep their modulus.
      if (issue && idle) begin
        cfg_valid <= 1'b1;
        mr_q_o <= cand_q;
        mr_q_bl_o <= cand_qbl;
        mr_qinv_o <= cand_qinv;
      end
      if (state == S_RUN) lock_id <= cand;
      state <= state == S_RUN ? (cand_ok && !cfg_match && !idle ? S_DRAIN : S_RUN)
                              : (issue || !cand_ok ? S_RUN : S_DRAIN);
      inflight <= inflight + CW'(issue) - CW'(mr_valid_i && tail_ok);
      tag_v <= {tag_v[LATENCY-2:0], mr_start_o};
      tag_id[0] <= mr_id;
      for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
      wr_ptr <= push ? (wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
      rd_ptr <= pop ? (rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1)) : rd_ptr;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      err_o <= err_o || (mr_valid_i && (!tail_ok || (full && !pop)));
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr] <= mr_result_i;
      fifo_id[wr_ptr] <= tail_ok ? tag_id[LATENCY-1] : '0;
    end
  end
endmodule

// File: tb/tb_montgomery_req_scheduler.sv
// tb_montgomery_req_scheduler: directed and randomized checks of the scheduler against a stand-in reducer and a
// reference model that tracks issue order, credit and modular results.
module tb_montgomery_req_scheduler;
  localparam int LAT = 21;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [255:0] req_x = '0, req_q = '0, req_qbl = '0, req_qinv = '0;
  logic resp_valid, resp_ready = 1'b1, mr_start_o, mr_valid_i, busy_o, err_o;
  logic [1:0] resp_id;
  logic [63:0] resp_data, mr_x_o, mr_q_o, mr_q_bl_o, mr_qinv_o, mr_result_i;
  logic [LAT-1:0] pv;
  logic [63:0] pd [LAT];
  logic inj = 1'b0;
  logic [63:0] inj_d = '0;
  int n_cmp = 0, n_err = 0, t = 0, mrr = 0, t0, n, q_bad;
  bit predict = 0;
  int sb_id[$], hs_id_log[$], hs_cyc_log[$], rid_log[$], rcyc_log[$];
  logic [63:0] sb_d[$], rd_log[$];

  montgomery_req_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_q_i(req_q), .req_qbl_i(req_qbl), .req_qinv_i(req_qinv),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id), .resp_data_o(resp_data),
    .mr_start_o(mr_start_o), .mr_x_o(mr_x_o), .mr_q_o(mr_q_o), .mr_q_bl_o(mr_q_bl_o), .mr_qinv_o(mr_qinv_o),
    .mr_result_i(mr_result_i), .mr_valid_i(mr_valid_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in reducer: one-step REDC computed at start, delivered LAT cycles later.
  function automatic logic [63:0] redc(logic [63:0] x, logic [63:0] q, logic [63:0] qbl, logic [63:0] qinv);
    logic [63:0] rm, m, tt;
    rm = (64'd1 << qbl) - 64'd1;
    m = ((x & rm) * qinv) & rm;
    tt = (x + m * q) >> qbl;
    return tt >= q ? tt - q : tt;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pv <= '0;
    else begin
      pv <= {pv[LAT-2:0], mr_start_o};
      pd[0] <= redc(mr_x_o, mr_q_o, mr_q_bl_o, mr_qinv_o);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign mr_valid_i = pv[LAT-1] | inj;
  assign mr_result_i = inj ? inj_d : pd[LAT-1];

  // Reference: x * (2^qbl)^-1 mod q, with the inverse found by search.
  function automatic logic [63:0] mont_ref(logic [63:0] x, logic [63:0] q, logic [63:0] qbl);
    longint r, ri;
    r = longint'((64'd1 << qbl) % q);
    ri = 0;
    for (longint i = 1; i < longint'(q); i++) if ((r * i) % longint'(q) == 1) ri = i;
    return ((x % q) * 64'(ri)) % q;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] x, input logic [63:0] q, input logic [63:0] qbl,
                         input logic [63:0] qinv);
    req_x[i*64 +: 64] = x;
    req_q[i*64 +: 64] = q;
    req_qbl[i*64 +: 64] = qbl;
    req_qinv[i*64 +: 64] = qinv;
    req_valid[i] = 1'b1;
  endtask

  // One clock: sample handshakes/responses mid-cycle, update the model, advance past the edge.
  task automatic tick();
    logic [3:0] hs, exp_r;
    int id;
    #1;
    hs = req_valid & req_ready;
    if (predict) begin
      exp_r = '0;
      if (sb_id.size() < 8)
        for (int k = 3; k >= 0; k--) if (req_valid[(mrr + k) % 4]) exp_r = 4'b1 << ((mrr + k) % 4);
      chk("pred_ready", 64'(req_ready), 64'(exp_r));
    end
    if (hs != 0) begin
      chk("hs_onehot", 64'($onehot(hs)), 1);
      id = $clog2(hs);
      sb_id.push_back(id);
      sb_d.push_back(mont_ref(req_x[id*64 +: 64], req_q[id*64 +: 64], req_qbl[id*64 +: 64]));
      hs_id_log.push_back(id);
      hs_cyc_log.push_back(t);
      mrr = (id + 1) % 4;
    end
    if (resp_valid && resp_ready) begin
      rid_log.push_back(int'(resp_id));
      rd_log.push_back(resp_data);
      rcyc_log.push_back(t);
      if (sb_id.size() == 0) chk("resp_unexpected", 64'(resp_valid), 0);
      else begin
        chk("resp_id", 64'(resp_id), 64'(sb_id.pop_front()));
        chk("resp_data", resp_data, sb_d.pop_front());
      end
    end
    @(posedge clk_i);
    #1;
    req_valid &= ~hs;
    t++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid = '0;
    inj = 1'b0;
    resp_ready = 1'b1;
    predict = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    sb_id.delete(); sb_d.delete(); hs_id_log.delete(); hs_cyc_log.delete();
    rid_log.delete(); rd_log.delete(); rcyc_log.delete();
    mrr = 0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 100, 17, 5, 15);
    #2;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_start", 64'(mr_start_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_rvalid", 64'(resp_valid), 0);
    chk("rst_mrq", mr_q_o, 0);
    // single request latency
    do_reset();
    set_req(0, 100, 17, 5, 15);
    t0 = t;
    tick();
    chk("t1_hs", 64'(hs_id_log.size()), 1);
    chk("t1_start", 64'(mr_start_o), 1);
    chk("t1_mrx", mr_x_o, 100);
    chk("t1_mrq", mr_q_o, 17);
    tick();
    chk("t1_start_pulse", 64'(mr_start_o), 0);
    while (t < t0 + 23) tick();
    chk("t1_rvalid", 64'(resp_valid), 1);
    chk("t1_rid", 64'(resp_id), 0);
    chk("t1_rdata", resp_data, 1);
    chk("t1_busy_hi", 64'(busy_o), 1);
    tick();
    chk("t1_busy_lo", 64'(busy_o), 0);
    chk("t1_lat", 64'(rcyc_log.size() > 0 ? rcyc_log[0] - t0 : -1), 23);
    // four requesters, same config
    do_reset();
    set_req(0, 100, 17, 5, 15); set_req(1, 50, 17, 5, 15);
    set_req(2, 100, 17, 5, 15); set_req(3, 50, 17, 5, 15);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_nhs", 64'(hs_id_log.size()), 4);
    if (hs_id_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 64'(hs_id_log[i]), 64'(i));
      chk("t2_consec", 64'(hs_cyc_log[3] - hs_cyc_log[0]), 3);
    end
    n = 0;
    while (rd_log.size() < 4 && n < 60) begin tick(); n++; end
    chk("t2_nresp", 64'(rd_log.size()), 4);
    if (rd_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_rdata", rd_log[i], (i % 2 == 0) ? 64'd1 : 64'd9);
        chk("t2_rid", 64'(rid_log[i]), 64'(i));
      end
    // config change forces a drain
    do_reset();
    set_req(0, 50, 17, 5, 15);
    tick();
    set_req(1, 20, 13, 4, 11);
    n = 0;
    q_bad = 0;
    while (hs_id_log.size() < 2 && n < 60) begin
      if (mr_q_o !== 64'd17 || mr_qinv_o !== 64'd15) q_bad++;
      tick();
      n++;
    end
    chk("t3_q_stable", 64'(q_bad), 0);
    chk("t3_nhs", 64'(hs_id_log.size()), 2);
    if (hs_id_log.size() == 2) chk("t3_stall", 64'(hs_cyc_log[1] - hs_cyc_log[0]), 23);
    chk("t3_q_new", mr_q_o, 13);
    chk("t3_qbl_new", mr_q_bl_o, 4);
    chk("t3_qinv_new", mr_qinv_o, 11);
    n = 0;
    while (rd_log.size() < 2 && n < 60) begin tick(); n++; end
    chk("t3_nresp", 64'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("t3_d0", rd_log[0], 9);
      chk("t3_d1", rd_log[1], mont_ref(20, 13, 4));
      chk("t3_id1", 64'(rid_log[1]), 1);
    end
    // credit limit with stalled responses
    do_reset();
    resp_ready = 1'b0;
    set_req(0, 100, 17, 5, 15); set_req(1, 50, 17, 5, 15);
    set_req(2, 100, 17, 5, 15); set_req(3, 50, 17, 5, 15);
    for (int i = 0; i < 40; i++) begin tick(); req_valid = 4'hF; end
    chk("t4_issues", 64'(hs_id_log.size()), 8);
    #1;
    chk("t4_ready0", 64'(req_ready), 0);
    chk("t4_busy", 64'(busy_o), 1);
    resp_ready = 1'b1;
    n = 0;
    while (rd_log.size() < 8 && n < 40) begin tick(); req_valid = 4'hF; n++; end
    chk("t4_resp8", 64'(rd_log.size() >= 8), 1);
    chk("t4_resume", 64'(hs_id_log.size() > 8), 1);
    req_valid = '0;
    n = 0;
    while ((sb_id.size() != 0 || busy_o) && n < 80) begin tick(); n++; end
    chk("t4_drained", 64'(sb_id.size()), 0);
    chk("t4_nodup", 64'(rd_log.size()), 64'(hs_id_log.size()));
    // reset with work in flight
    do_reset();
    set_req(0, 100, 17, 5, 15); set_req(1, 50, 17, 5, 15); set_req(2, 100, 17, 5, 15);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_inflight", 64'(hs_id_log.size()), 3);
    rst_ni = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t5_ready", 64'(req_ready), 0);
    chk("t5_busy", 64'(busy_o), 0);
    chk("t5_rvalid", 64'(resp_valid), 0);
    chk("t5_mrx", mr_x_o, 0);
    do_reset();
    set_req(0, 100, 17, 5, 15);
    for (int i = 0; i < 50; i++) tick();
    chk("t5_nresp", 64'(rd_log.size()), 1);
    if (rd_log.size() == 1) chk("t5_data", rd_log[0], 1);
    chk("t5_err", 64'(err_o), 0);
    // result with no matching tag
    do_reset();
    inj_d = 64'd123;
    inj = 1'b1;
    sb_id.push_back(0);
    sb_d.push_back(64'd123);
    tick();
    inj = 1'b0;
    chk("t6_err", 64'(err_o), 1);
    chk("t6_rvalid", 64'(resp_valid), 1);
    chk("t6_rdata", resp_data, 123);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_sticky", 64'(err_o), 1);
    chk("t6_busy", 64'(busy_o), 0);
    do_reset();
    chk("t6_err_clr", 64'(err_o), 0);
    // randomized traffic, single config, model predicts every grant
    predict = 1;
    for (int c = 0; c < 600; c++) begin
      resp_ready = $urandom_range(3) != 0;
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(1) == 1) set_req(i, 64'($urandom_range(543)), 17, 5, 15);
      tick();
    end
    predict = 0;
    req_valid = '0;
    resp_ready = 1'b1;
    n = 0;
    while ((sb_id.size() != 0 || busy_o) && n < 100) begin tick(); n++; end
    chk("rnd_drained", 64'(sb_id.size()), 0);
    chk("rnd_count", 64'(rd_log.size()), 64'(hs_id_log.size()));
    chk("rnd_err", 64'(err_o), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
